// File: rtl/sine_ctrl_pkg.sv
// sine_ctrl_pkg: shared state encoding, LUT geometry and quadrant fold for the sine sequencer
package sine_ctrl_pkg;
  localparam int LUT_AW = 5;
  localparam int LUT_DW = 8;
  typedef enum logic [1:0] {IDLE, RUN, RUN_C, DRAIN} state_t;
  function automatic logic [LUT_AW:0] fold(input logic [1:0] quad, input logic [LUT_AW-1:0] idx);
    return {quad[1], quad[0] ? ~idx : idx};
  endfunction
endpackage

// File: rtl/sine_fold.sv
// sine_fold: maps quadrant/index to a quarter-wave LUT address and applies the half-wave sign
module sine_fold import sine_ctrl_pkg::*; (
  input  logic [1:0]        quad,
  input  logic [LUT_AW-1:0] idx,
  input  logic [LUT_DW-1:0] mag,
  output logic [LUT_AW-1:0] addr,
  output logic [LUT_DW-1:0] value
);
  logic neg;
  always_comb {neg, addr} = fold(quad, idx);
  assign value = neg ? -mag : mag;
endmodule

// File: rtl/sine_wave_ctrl.sv
// sine_wave_ctrl: phase-accumulator sine sequencer on a shared quarter-wave LUT; SINE_COS_EN adds time-shared cos_sample
module sine_wave_ctrl import sine_ctrl_pkg::*; #(
  parameter int PHASE_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] step,
  output logic [LUT_AW-1:0]  lut_addr,
  input  logic [LUT_DW-1:0]  lut_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LUT_DW-1:0]  sample,
  output logic               wrap,
`ifdef SINE_COS_EN
  output logic [LUT_DW-1:0]  cos_sample,
`endif
  output logic               busy
);
  state_t state;
  logic [PHASE_W-1:0] phase, step_q;
  logic [PHASE_W:0] sum;
  logic [1:0] quad;
  logic [LUT_DW-1:0] value;
  logic slot_free;
`ifdef SINE_COS_EN
  logic [LUT_DW-1:0] mag_q;
`endif
  assign sum = {1'b0, phase} + {1'b0, step_q};
  assign quad = phase[PHASE_W-1 -: 2] + {1'b0, state == RUN_C};
  assign slot_free = !out_valid || out_ready;
  assign busy = state != IDLE;
  sine_fold u_fold (
    .quad(quad),
    .idx(phase[PHASE_W-3 -: LUT_AW]),
    .mag(lut_data),
    .addr(lut_addr),
    .value(value)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      step_q <= '0;
      out_valid <= 1'b0;
      sample <= '0;
      wrap <= 1'b0;
`ifdef SINE_COS_EN
      cos_sample <= '0;
      mag_q <= '0;
`endif
    end else begin
      wrap <= 1'b0;
      out_valid <= out_valid && !out_ready;
      case (state)
        IDLE: begin
          if (phase_clr) phase <= '0;
          if (en) begin
            step_q <= step;
            state <= RUN;
          end
        end
        RUN:
          if (!en) state <= DRAIN;
`ifdef SINE_COS_EN
          else if (slot_free) begin
            mag_q <= value;
            state <= RUN_C;
          end
        RUN_C: begin
          sample <= mag_q;
          cos_sample <= value;
          out_valid <= 1'b1;
          {wrap, phase} <= sum;
          state <= RUN;
        end
`else
          else if (slot_free) begin
            sample <= value;
            out_valid <= 1'b1;
            {wrap, phase} <= sum;
          end
`endif
        DRAIN: if (!out_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sine_wave_ctrl.sv
// tb_sine_wave_ctrl: randomized scoreboard bench comparing the sample stream against an ideal sampled sine
module tb_sine_wave_ctrl;
  localparam real PI = 3.14159265358979;
`ifdef SINE_COS_EN
  localparam int PER = 50;
`else
  localparam int PER = 100;
`endif
  logic clk = 0, rst = 1, en = 0, phase_clr = 0, out_ready = 0;
  logic [15:0] step = 0;
  logic [4:0] lut_addr;
  logic [7:0] lut_data, sample;
  logic out_valid, wrap, busy;
`ifdef SINE_COS_EN
  logic [7:0] cos_sample;
`endif
  logic [7:0] lut_mem [32];
  logic [15:0] exp_q[$];
  logic [15:0] e;
  logic [7:0] first_val = 0, prev_sample = 0;
  bit prev_stall = 0, rand_ready = 0;
  int n_cmp = 0, n_bad = 0, acc_cnt = 0, wrap_cnt = 0, model_phase = 0, model_step = 0;

  always #5 clk = ~clk;
  assign lut_data = lut_mem[lut_addr];

  sine_wave_ctrl #(.PHASE_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .phase_clr(phase_clr), .step(step),
    .lut_addr(lut_addr), .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready),
    .sample(sample), .wrap(wrap),
`ifdef SINE_COS_EN
    .cos_sample(cos_sample),
`endif
    .busy(busy)
  );

  function automatic logic [7:0] ref_val(input int ph, input real shift);
    real r;
    int m;
    r = 127.0 * $sin((real'((ph >> 9) & 127) + 0.5) * PI / 64.0 + shift);
    m = $rtoi((r < 0.0 ? -r : r) + 0.5);
    return 8'(r < 0.0 ? -m : m);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_run(input int s);
    exp_q.delete();
    for (int k = 0; k < 700; k++)
      exp_q.push_back({ref_val(model_phase + k * s, PI / 2.0), ref_val(model_phase + k * s, 0.0)});
    model_step = s;
    acc_cnt = 0;
    wrap_cnt = 0;
    step = 16'(s);
    en = 1;
  endtask

  task automatic stop_run();
    int b, total;
    en = 0;
    rand_ready = 0;
    out_ready = 1;
    b = 0;
    while (busy && b < 200) begin
      tick();
      b++;
    end
    chk("drain_timeout_busy", busy, 0);
    total = model_phase + acc_cnt * model_step;
    chk("wrap_count", wrap_cnt, total >>> 16);
    model_phase = total & 16'hFFFF;
  endtask

  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sample", sample, prev_sample);
      end
      if (wrap) wrap_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("queue_underflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sample", int'($signed(sample)), int'($signed(e[7:0])));
`ifdef SINE_COS_EN
          chk("cos_sample", int'($signed(cos_sample)), int'($signed(e[15:8])));
`endif
        end
        if (acc_cnt == 0) first_val = sample;
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sample = sample;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a, len;
    for (int i = 0; i < 32; i++) lut_mem[i] = 8'($rtoi(127.0 * $sin((real'(i) + 0.5) * PI / 64.0) + 0.5));
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sample", sample, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_lut_addr", lut_addr, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    out_ready = 1;
    start_run(512);
    repeat (200) tick();
    a = acc_cnt;
    repeat (100) tick();
    chk("throughput", acc_cnt - a, PER);
    stop_run();
    start_run(512);
    repeat (40) tick();
    out_ready = 0;
    repeat (5) tick();
    out_ready = 1;
    repeat (40) tick();
    stop_run();
    start_run(1000);
    repeat (20) tick();
    out_ready = 0;
    repeat (2) tick();
    en = 0;
    repeat (6) tick();
    chk("drain_busy", busy, 1);
    chk("drain_valid", out_valid, 1);
    stop_run();
    start_run(16'h0100);
    repeat (30) tick();
    step = 16'h1234;
    repeat (30) tick();
    stop_run();
    start_run(512);
    repeat (20) tick();
    out_ready = 0;
    tick();
    rst = 1;
    en = 0;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sample", sample, 0);
    chk("midrst_lut_addr", lut_addr, 0);
    chk("midrst_busy", busy, 0);
    rst = 0;
    model_phase = 0;
    out_ready = 1;
    start_run(512);
    repeat (10) tick();
    stop_run();
    phase_clr = 1;
    tick();
    phase_clr = 0;
    model_phase = 0;
    start_run(512);
    repeat (10) tick();
    stop_run();
    chk("first_after_clr", first_val, 3);
    for (int it = 0; it < 6; it++) begin
      rand_ready = 1;
      start_run(int'($urandom_range(1, 65535)));
      len = int'($urandom_range(20, 200));
      for (int c = 0; c < len; c++) begin
        tick();
        phase_clr = ($urandom_range(0, 15) == 0);
      end
      phase_clr = 0;
      stop_run();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
